// File: rtl/float12_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float12_pkg
// Description : 12-bit float format shared by the float_arith datapath.
//               Layout: sign[11], exponent[10:6] (bias 15), mantissa[5:0].
// Revision    : 1.0 - initial release
// ============================================================================
package float12_pkg;

  localparam int FP12_W        = 12;
  localparam int FP12_EXP_BIAS = 15;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [5:0] man;
  } fp12_t;

  localparam fp12_t FP12_ZERO = 12'h000;

endpackage
`default_nettype wire

// File: rtl/add_12.sv
`default_nettype none
// ============================================================================
// Module      : add_12
// Description : Pipelined 12-bit float adder. Combinational add on the input
//               operands followed by STAGES output registers. A zero exponent
//               is treated as zero, results truncate toward zero, overflow
//               saturates to exponent 31 with zero mantissa, underflow flushes
//               to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module add_12
  import float12_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  fp12_t data_a_i,
  input  fp12_t data_b_i,
  output fp12_t data_sum_o
);

  function automatic fp12_t fp12_add(input fp12_t a, input fp12_t b);
    fp12_t       x;
    fp12_t       y;
    fp12_t       r;
    logic [9:0]  mx;
    logic [9:0]  my;
    logic [10:0] s;
    logic [4:0]  d;
    int          e;
    // Order by magnitude so the larger operand fixes sign and exponent.
    if (a[10:0] >= b[10:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    // Hidden bit plus three guard bits below the mantissa.
    mx = (x.exp != 5'd0) ? {1'b1, x.man, 3'b000} : 10'd0;
    my = (y.exp != 5'd0) ? {1'b1, y.man, 3'b000} : 10'd0;
    d  = x.exp - y.exp;
    my = (d > 5'd9) ? 10'd0 : (my >> d);
    if (x.sign == y.sign) s = {1'b0, mx} + {1'b0, my};
    else                  s = {1'b0, mx} - {1'b0, my};
    e = int'(x.exp);
    r = FP12_ZERO;
    if (s != 11'd0) begin
      if (s[10]) begin
        s = s >> 1;
        e = e + 1;
      end else begin
        for (int i = 0; i < 9; i++) begin
          if (!s[9]) begin
            s = s << 1;
            e = e - 1;
          end
        end
      end
      if (e > 2 * FP12_EXP_BIAS) r = {x.sign, 5'h1F, 6'h00};
      else if (e > 0)            r = {x.sign, e[4:0], s[8:3]};
    end
    return r;
  endfunction

  fp12_t w_sum;
  fp12_t r_pipe [STAGES];

  // Combinational sum of the sampled operands.
  always_comb w_sum = fp12_add(data_a_i, data_b_i);

  // Output delay line that sets the adder latency.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < STAGES; i++) r_pipe[i] <= FP12_ZERO;
    end else begin
      r_pipe[0] <= w_sum;
      for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign data_sum_o = r_pipe[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Scans from the pointer upward modulo N,
//               grants the first requester, then moves the pointer one past
//               the winner. Grant is combinational and zero during reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_id_o
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_sel;
  logic          w_hit;

  // Find the first request at or above the pointer; the descending scan
  // leaves the lowest offset as the final winner.
  always_comb begin
    w_hit = 1'b0;
    w_sel = r_ptr;
    w_idx = '0;
    for (int off = N - 1; off >= 0; off--) begin
      w_idx = PW'((int'(r_ptr) + off) % N);
      if (req_i[w_idx]) begin
        w_hit = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  // One-hot grant, suppressed while disabled or in reset.
  always_comb begin
    grant_o = '0;
    if (enable_i && w_hit && !rst_i) grant_o[w_sel] = 1'b1;
  end

  assign grant_id_o = w_sel;

  // Pointer advances past the winner only when a grant is issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (|grant_o) begin
      r_ptr <= (w_sel == PW'(N - 1)) ? '0 : w_sel + PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/add_12_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : add_12_arbiter
// Description : Shares one pipelined add_12 among NUM_REQ requesters. One
//               round-robin issue per cycle; a tag pipe running beside the
//               adder steers each sum back to its originator. The issue
//               register is the first of ADD_LAT datapath stages, the adder
//               supplies the remaining ADD_LAT-1, and the response register
//               adds one more (ADD_LAT must be at least 2).
// Revision    : 1.0 - initial release
// ============================================================================
module add_12_arbiter
  import float12_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            enable_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*FP12_W-1:0]       req_a_i,
  input  logic [NUM_REQ*FP12_W-1:0]       req_b_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [FP12_W-1:0]               rsp_data_o,
  output logic [ID_W-1:0]                 rsp_id_o,
  output logic                            busy_o,
  output logic [$clog2(ADD_LAT+2)-1:0]    in_flight_o
);

  localparam int CNT_W = $clog2(ADD_LAT + 2);

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic               w_hs;
  fp12_t              w_a;
  fp12_t              w_b;
  fp12_t              w_sum;
  logic               w_rst_n;
  logic               w_tail_v;
  logic [ID_W-1:0]    w_tail_id;
  logic               w_rsp_any;

  fp12_t              r_iss_a;
  fp12_t              r_iss_b;
  logic [ADD_LAT-1:0] r_tag_v;
  logic [ID_W-1:0]    r_tag_id [ADD_LAT];
  logic [CNT_W-1:0]   r_cnt;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (ID_W)
  ) u_arb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .req_i      (req_valid_i),
    .grant_o    (w_grant),
    .grant_id_o (w_grant_id)
  );

  assign req_ready_o = w_grant;
  // A grant is only ever given to an asserted valid, so any grant is a handshake.
  assign w_hs        = |(req_valid_i & w_grant);

  // Select the granted requester's operands; zero when nothing is granted.
  always_comb begin
    w_a = FP12_ZERO;
    w_b = FP12_ZERO;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_a = req_a_i[k*FP12_W +: FP12_W];
        w_b = req_b_i[k*FP12_W +: FP12_W];
      end
    end
  end

  // Issue registers: idle cycles feed 0+0 into the adder.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_iss_a <= FP12_ZERO;
      r_iss_b <= FP12_ZERO;
    end else begin
      r_iss_a <= w_a;
      r_iss_b <= w_b;
    end
  end

  // Tag pipe: stage 0 sits beside the issue registers, the tail lines up
  // with data_sum_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag_v <= '0;
      for (int i = 0; i < ADD_LAT; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v     <= {r_tag_v[ADD_LAT-2:0], w_hs};
      r_tag_id[0] <= w_grant_id;
      for (int i = 1; i < ADD_LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  assign w_tail_v  = r_tag_v[ADD_LAT-1];
  assign w_tail_id = r_tag_id[ADD_LAT-1];
  assign w_rst_n   = ~rst_i;

  add_12 #(
    .STAGES (ADD_LAT - 1)
  ) u_add (
    .clk_i      (clk_i),
    .rst_n_i    (w_rst_n),
    .data_a_i   (r_iss_a),
    .data_b_i   (r_iss_b),
    .data_sum_o (w_sum)
  );

  // Response register: pulse the owner's valid, hold data and id otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      rsp_id_o    <= '0;
    end else if (w_tail_v) begin
      rsp_valid_o <= NUM_REQ'(1) << w_tail_id;
      rsp_data_o  <= w_sum;
      rsp_id_o    <= w_tail_id;
    end else begin
      rsp_valid_o <= '0;
    end
  end

  assign w_rsp_any = |rsp_valid_o;

  // Outstanding-op counter: issue increments, response decrements.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      case ({w_hs, w_rsp_any})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign in_flight_o = r_cnt;
  assign busy_o      = (r_cnt != '0);

endmodule
`default_nettype wire
